// File: rtl/pc_unit.sv
// Program-counter unit with call/return stack, stall, trap redirect
// and misaligned-target detection. Drives the fetch address.
module pc_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h100),
  parameter int RAS_DEPTH = 4,
  parameter int STEP = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pc_we,
  input  logic [2:0]                    pc_op,
  input  logic [ADDR_W-1:0]             pc_imm,
  input  logic                          stall,
  input  logic                          trap_req,
  output logic [ADDR_W-1:0]             pc_o,
  output logic [ADDR_W-1:0]             epc_o,
  output logic                          misalign_o,
  output logic [$clog2(RAS_DEPTH):0]    ras_count_o,
  output logic                          ras_ovf_o,
  output logic                          ras_unf_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t STEP_W = addr_t'(STEP);

  typedef enum logic [2:0] {
    OP_ADD_STEP = 3'd0,
    OP_ADD_IMM  = 3'd1,
    OP_SET_IMM  = 3'd2,
    OP_CLEAR    = 3'd3,
    OP_CALL     = 3'd4,
    OP_RET      = 3'd5
  } op_e;

  addr_t          pc_q, pc_d;
  addr_t          epc_q, epc_d;
  addr_t          ras_q [RAS_DEPTH];
  addr_t          ras_d [RAS_DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mis_q, mis_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  addr_t          tgt;
  logic           chk;
  logic           ras_full;

  assign ras_full = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    ras_d  = ras_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    mis_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    tgt    = pc_q;
    chk    = 1'b0;

    if (trap_req) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
    end else if (!stall && pc_we) begin
      case (pc_op)
        OP_ADD_STEP: pc_d = pc_q + STEP_W;
        OP_ADD_IMM: begin
          tgt = pc_q + pc_imm;
          chk = 1'b1;
        end
        OP_SET_IMM: begin
          tgt = pc_imm;
          chk = 1'b1;
        end
        OP_CLEAR: begin
          pc_d   = RESET_VEC;
          wptr_d = '0;
          cnt_d  = '0;
        end
        OP_CALL: begin
          tgt = pc_q + pc_imm;
          chk = 1'b1;
          ras_d[wptr_q] = pc_q + STEP_W;
          wptr_d = wptr_q + PW'(1);
          // full stack: oldest entry is the one just overwritten
          if (ras_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + CW'(1);
        end
        OP_RET: begin
          chk = 1'b1;
          if (cnt_q != '0) begin
            tgt    = ras_q[wptr_q - PW'(1)];
            wptr_d = wptr_q - PW'(1);
            cnt_d  = cnt_q - CW'(1);
          end else begin
            tgt   = pc_imm;
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (chk) begin
        if ((tgt % STEP_W) != '0) begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
          mis_d = 1'b1;
        end else begin
          pc_d = tgt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      ras_q  <= '{default: '0};
      wptr_q <= '0;
      cnt_q  <= '0;
      mis_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      ras_q  <= ras_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      mis_q  <= mis_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign pc_o        = pc_q;
  assign epc_o       = epc_q;
  assign misalign_o  = mis_q;
  assign ras_count_o = cnt_q;
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model compared every cycle,
// plus directed literal expectations from hand-worked sequences.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_we = 1'b0;
  logic [2:0]  pc_op = '0;
  logic [31:0] pc_imm = '0;
  logic        stall = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] pc_o, epc_o;
  logic        misalign_o, ras_ovf_o, ras_unf_o;
  logic [2:0]  ras_count_o;

  pc_unit #(
    .ADDR_W(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100),
    .RAS_DEPTH(4), .STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .pc_we(pc_we), .pc_op(pc_op),
    .pc_imm(pc_imm), .stall(stall), .trap_req(trap_req),
    .pc_o(pc_o), .epc_o(epc_o), .misalign_o(misalign_o),
    .ras_count_o(ras_count_o), .ras_ovf_o(ras_ovf_o),
    .ras_unf_o(ras_unf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  bit m_mis, m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    bit ck;
    m_mis = 0; m_ovf = 0; m_unf = 0;
    ck = 0; t = 0;
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ras.delete();
    end else if (trap_req) begin
      m_epc = m_pc; m_pc = 32'h100;
    end else if (!stall && pc_we) begin
      case (pc_op)
        3'd0: m_pc = m_pc + 4;
        3'd1: begin t = m_pc + pc_imm; ck = 1; end
        3'd2: begin t = pc_imm; ck = 1; end
        3'd3: begin m_pc = 32'h0; m_ras.delete(); end
        3'd4: begin
          t = m_pc + pc_imm; ck = 1;
          if (m_ras.size() == 4) begin
            void'(m_ras.pop_front()); m_ovf = 1;
          end
          m_ras.push_back(m_pc + 4);
        end
        3'd5: begin
          ck = 1;
          if (m_ras.size() > 0) t = m_ras.pop_back();
          else begin t = pc_imm; m_unf = 1; end
        end
        default: ;
      endcase
      if (ck) begin
        if (t % 4 != 0) begin
          m_epc = m_pc; m_pc = 32'h100; m_mis = 1;
        end else m_pc = t;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc_o, m_pc);
      check("epc", epc_o, m_epc);
      check("cnt", 32'(ras_count_o), 32'(m_ras.size()));
      check("mis", 32'(misalign_o), 32'(m_mis));
      check("ovf", 32'(ras_ovf_o), 32'(m_ovf));
      check("unf", 32'(ras_unf_o), 32'(m_unf));
    end
  end

  task automatic cyc(input bit rst, input bit we, input logic [2:0] op,
                     input logic [31:0] imm, input bit st, input bit tr);
    reset = rst; pc_we = we; pc_op = op; pc_imm = imm;
    stall = st; trap_req = tr;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic rst1();
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic op(input logic [2:0] o, input logic [31:0] imm);
    cyc(0, 1, o, imm, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    rst1();
    check("L_rst_pc", pc_o, 32'h0);
    check("L_rst_epc", epc_o, 32'h0);
    check("L_rst_cnt", 32'(ras_count_o), 32'h0);

    for (int i = 1; i <= 3; i++) begin
      op(3'd0, 0);
      check("L_step", pc_o, 32'(4 * i));
    end

    rst1();
    op(3'd0, 0); op(3'd0, 0);
    op(3'd4, 32'h20);
    check("L_call_pc", pc_o, 32'h28);
    check("L_call_cnt", 32'(ras_count_o), 32'd1);
    op(3'd5, 0);
    check("L_ret_pc", pc_o, 32'hc);
    check("L_ret_cnt", 32'(ras_count_o), 32'd0);

    rst1();
    for (int i = 0; i < 5; i++) op(3'd4, 32'h10);
    check("L_ovf", 32'(ras_ovf_o), 32'd1);
    check("L_ovf_cnt", 32'(ras_count_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      op(3'd5, 0);
      check("L_ret_seq", pc_o, 32'h44 - 32'(16 * i));
    end
    op(3'd5, 32'h80);
    check("L_unf_pc", pc_o, 32'h80);
    check("L_unf", 32'(ras_unf_o), 32'd1);
    op(3'd6, 32'h40);
    check("L_rsv_pc", pc_o, 32'h80);

    rst1();
    op(3'd2, 32'h40);
    op(3'd2, 32'h102);
    check("L_mis_pc", pc_o, 32'h100);
    check("L_mis_epc", epc_o, 32'h40);
    check("L_mis", 32'(misalign_o), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    check("L_mis_clr", 32'(misalign_o), 32'd0);

    rst1();
    op(3'd2, 32'h20);
    for (int i = 0; i < 3; i++) cyc(0, 1, 3'd0, 0, 1, 0);
    check("L_stall_pc", pc_o, 32'h20);
    cyc(0, 1, 3'd0, 0, 1, 1);
    check("L_trap_pc", pc_o, 32'h100);
    check("L_trap_epc", epc_o, 32'h20);

    // misaligned CALL still pushes; misaligned empty RET flags both
    rst1();
    op(3'd2, 32'h20);
    op(3'd4, 32'h2);
    check("L_mcall_cnt", 32'(ras_count_o), 32'd1);
    op(3'd5, 0);
    check("L_mcall_ret", pc_o, 32'h24);
    op(3'd5, 32'h81);
    check("L_mret_pc", pc_o, 32'h100);
    op(3'd1, 32'h8);
    check("L_addimm", pc_o, 32'h108);
    op(3'd4, 32'h8); op(3'd3, 0);
    check("L_clear_cnt", 32'(ras_count_o), 32'd0);

    rst1();
    op(3'd4, 32'h8); op(3'd4, 32'h8);
    check("L_two_cnt", 32'(ras_count_o), 32'd2);
    cyc(1, 1, 3'd4, 32'h8, 0, 0);
    check("L_rcall_pc", pc_o, 32'h0);
    check("L_rcall_cnt", 32'(ras_count_o), 32'd0);
    check("L_rcall_ovf", 32'(ras_ovf_o), 32'd0);

    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 3'($urandom_range(0, 7)),
          32'($urandom_range(0, 63)) & 32'hfffffffc |
            32'($urandom_range(0, 3) == 0),
          $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit that replaces the fixed-width PC register of the single-cycle core. It supports the existing four PC operations, plus call/return through a circular return-address stack (RAS), stall, trap redirection and misaligned-target detection. It sits between the decode/branch logic and instruction memory, and drives the instruction fetch address.

Parameters:
ADDR_W, 32, width of PC, immediates and all address outputs
RESET_VEC, 0, PC value after reset and after CLEAR
TRAP_VEC, 'h100, PC loaded on trap or misaligned target
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
STEP, 4, sequential increment; also the alignment requirement for every target

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
pc_we  in  1  apply pc_op this cycle
pc_op  in  3  0 ADD_STEP, 1 ADD_IMM, 2 SET_IMM, 3 CLEAR, 4 CALL, 5 RET, 6/7 reserved (hold)
pc_imm  in  ADDR_W  offset (ADD_IMM, CALL) or absolute target (SET_IMM, RET fallback)
stall  in  1  hold PC and RAS
trap_req  in  1  external trap request
pc_o  out  ADDR_W  current PC (fetch address)
epc_o  out  ADDR_W  PC at last trap or misalign event
misalign_o  out  1  one-cycle pulse: computed target was misaligned
ras_count_o  out  log2(RAS_DEPTH)+1  valid RAS entries
ras_ovf_o  out  1  one-cycle pulse: CALL overwrote oldest entry
ras_unf_o  out  1  one-cycle pulse: RET with empty RAS

Behaviour:
- All state updates on posedge clk. pc_o is the registered PC, so a change is visible the cycle after the op.
- Reset: pc_o=RESET_VEC, epc_o=0, RAS emptied (count 0, pointer 0), all pulses 0.
- Priority, highest first: reset > trap_req > stall > pc_we.
- trap_req: PC<=TRAP_VEC, epc<=PC. Applies even while stall is high. RAS is unchanged.
- stall (no trap): PC, RAS and epc hold. Pulses are 0.
- pc_we=0: PC and RAS hold.
- pc_we=1, target computed modulo 2^ADDR_W:
  - ADD_STEP: PC+STEP.
  - ADD_IMM: PC+pc_imm.
  - SET_IMM: pc_imm.
  - CLEAR: RESET_VEC; RAS emptied.
  - CALL: target PC+pc_imm; PC+STEP is pushed onto the RAS.
  - RET: target is the RAS top, which is popped. If the RAS is empty, target is pc_imm, ras_unf_o pulses, and count stays 0.
  - Reserved ops: hold; no flags.
- RAS is a circular buffer. A push when count==RAS_DEPTH overwrites the oldest entry, count stays RAS_DEPTH, and ras_ovf_o pulses. The write pointer wraps modulo RAS_DEPTH.
- Alignment: if target mod STEP != 0 for ADD_IMM, SET_IMM, CALL or RET:
  - PC<=TRAP_VEC, epc<=PC, misalign_o pulses.
  - The RAS is still updated: a CALL still pushes, a RET still pops.
  - ADD_STEP and CLEAR are never checked.
- Pulse outputs are registered. Each is high exactly in the cycle after its causing edge, then returns to 0.
- reset asserted mid-sequence discards any pending op in that cycle. No partial RAS update is allowed.

Test Plan:
- Reset, then 3 cycles pc_we=1 ADD_STEP -> pc_o 0,4,8,12; ras_count_o 0.
- From PC=8, CALL imm=0x20 -> pc_o=0x28, ras_count_o=1. Then RET -> pc_o=0xC, ras_count_o=0.
- RAS_DEPTH=4: 5 CALLs imm=0x10 from PC=0 -> ras_ovf_o pulses on 5th, count=4. Then 4 RETs return 0x44,0x34,0x24,0x14. A 5th RET with imm=0x80 -> pc_o=0x80, ras_unf_o pulses.
- From PC=0x40, SET_IMM imm=0x102 -> pc_o=0x100, epc_o=0x40, misalign_o pulses 1 cycle.
- From PC=0x20, stall=1 with pc_we=1 ADD_STEP for 3 cycles -> pc_o stays 0x20. Then stall=1 with trap_req=1 -> pc_o=0x100, epc_o=0x20.
- Push 2 entries, then reset during a CALL -> pc_o=0, ras_count_o=0, no pulses.
